// File: rtl/normalize_pkg.sv
// Shared definitions for the normalization pipeline: lane width,
// controller state encoding and accumulator sizing.
package normalize_pkg;

  localparam int LANE_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DIV   = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Accumulator wide enough to hold the sum of 2**log2n full-scale lanes.
  function automatic int acc_width(input int log2n);
    return LANE_W + log2n;
  endfunction

endpackage

// File: rtl/normalize_mean_chunk_sum.sv
// Combinational signed sum of P sign-extended 16-bit lanes.
// Result width 16+log2(P) cannot overflow.
module normalize_mean_chunk_sum
  import normalize_pkg::*;
#(
  parameter int P = 8
) (
  input  logic [P*LANE_W-1:0]                 lanes,
  output logic signed [LANE_W+$clog2(P)-1:0]  sum
);

  localparam int SUM_W = LANE_W + $clog2(P);

  // Sign-extend every lane and add; synthesis balances the chain into a tree.
  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < P; i++) begin
      sum = sum + SUM_W'($signed(lanes[i*LANE_W +: LANE_W]));
    end
  end

endmodule

// File: rtl/normalize_mean_module.sv
// Lane-mean stage: captures one N-lane vector, accumulates P lanes per
// cycle, divides by N with an arithmetic shift and presents x and mu together.
// Build option: define NORMALIZE_MEAN_ROUND_EN for round-half-up instead
// of floor in the divide step.
module normalize_mean_module
  import normalize_pkg::*;
#(
  parameter int N     = 64,
  parameter int LOG2N = 6,
  parameter int P     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*LANE_W-1:0] x_in,
  output logic [N*LANE_W-1:0] x_out,
  output logic [LANE_W-1:0]   mu,
  output logic                out_valid,
  input  logic                out_ready
);

  localparam int ACC_W  = acc_width(LOG2N);
  localparam int SUM_W  = LANE_W + $clog2(P);
  localparam int CHUNKS = N / P;
  localparam int CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  state_t                    state;
  state_t                    state_next;
  logic [N*LANE_W-1:0]       x_reg;
  logic signed [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]          cnt;
  logic [P*LANE_W-1:0]       chunk_lanes;
  logic signed [SUM_W-1:0]   chunk_sum;
  logic [LANE_W-1:0]         mu_next;
  logic                      last_chunk;

  assign last_chunk = (cnt == CNT_W'(CHUNKS - 1));
  assign x_out      = x_reg;

  // Select the chunk of lanes addressed by the chunk counter.
  always_comb begin
    chunk_lanes = x_reg[int'(cnt)*P*LANE_W +: P*LANE_W];
  end

  normalize_mean_chunk_sum #(.P(P)) u_chunk_sum (
    .lanes (chunk_lanes),
    .sum   (chunk_sum)
  );

`ifdef NORMALIZE_MEAN_ROUND_EN
  localparam int RND_W = ACC_W + 1;
  localparam int HALF  = 1 << (LOG2N - 1);

  logic signed [RND_W-1:0] acc_rnd;
  logic signed [RND_W-1:0] acc_rnd_sh;

  // Round-half-up: add half an LSB of the quotient before the shift, clamp at max.
  always_comb begin
    acc_rnd    = RND_W'(acc) + RND_W'(HALF);
    acc_rnd_sh = acc_rnd >>> LOG2N;
    if (acc_rnd_sh > $signed(RND_W'(32767))) begin
      mu_next = 16'h7FFF;
    end else begin
      mu_next = acc_rnd_sh[LANE_W-1:0];
    end
  end
`else
  // Floor division by N: arithmetic shift rounds toward -inf.
  always_comb begin
    mu_next = LANE_W'(acc >>> LOG2N);
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)   state_next = ACCUM;
      ACCUM:   if (last_chunk) state_next = DIV;
      DIV:                     state_next = HOLD;
      HOLD:    if (out_ready)  state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from the registered state only.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == HOLD);
  end

  // Datapath: capture, chunked accumulation, divide.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_reg <= '0;
      acc   <= '0;
      cnt   <= '0;
      mu    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_reg <= x_in;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        ACCUM: begin
          acc <= acc + ACC_W'(chunk_sum);
          cnt <= cnt + CNT_W'(1);
        end
        DIV: begin
          mu <= mu_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_normalize_mean_module.sv
// Directed self-checking bench for normalize_mean_module (N=64, P=8).
// Expectations switch with NORMALIZE_MEAN_ROUND_EN.
module tb_normalize_mean_module;

  localparam int N  = 64;
  localparam int LW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [N*LW-1:0] x_in;
  logic [N*LW-1:0] x_out;
  logic [LW-1:0]   mu;
  logic            out_valid;
  logic            out_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  normalize_mean_module #(.N(64), .LOG2N(6), .P(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .x_out     (x_out),
    .mu        (mu),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a vector for exactly one edge (caller ensures in_ready=1).
  task automatic send(input logic [N*LW-1:0] v);
    x_in     = v;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Wait for out_valid with a bound; reports edges taken and timeout.
  task automatic wait_valid(output int n, output bit timeout);
    n       = 0;
    timeout = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      n++;
      if (out_valid) begin
        timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; x_in = '0;
    tick(); tick();
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (mu !== 16'h0000) begin errors++; $display("FAIL reset_mu got %h want 0000", mu); end
    checks++; if (x_out !== '0) begin errors++; $display("FAIL reset_x_out got nonzero want 0"); end
  endtask

  task automatic test_basic();
    logic [N*LW-1:0] v;
    int n; bit to;
    for (int i = 0; i < N; i++) v[i*LW +: LW] = 16'h0010;
    out_ready = 1'b1;
    send(v);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_busy got %b want 0", in_ready); end
    wait_valid(n, to);
    checks++; if (to || n != 9) begin errors++; $display("FAIL basic_latency got %0d (timeout %0d) want 9", n, to); end
    checks++; if (mu !== 16'h0010) begin errors++; $display("FAIL basic_mu got %h want 0010", mu); end
    checks++; if (x_out !== v) begin errors++; $display("FAIL basic_x_out got %h want %h", x_out[31:0], v[31:0]); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_back got %b want 1", in_ready); end
  endtask

  task automatic test_extremes();
    logic [N*LW-1:0] v;
    int n; bit to;
    for (int i = 0; i < N; i++) v[i*LW +: LW] = 16'h7FFF;
    send(v);
    wait_valid(n, to);
    checks++; if (to || mu !== 16'h7FFF) begin errors++; $display("FAIL max_mu got %h (timeout %0d) want 7fff", mu, to); end
    tick();
    for (int i = 0; i < N; i++) v[i*LW +: LW] = 16'h8000;
    send(v);
    wait_valid(n, to);
    checks++; if (to || mu !== 16'h8000) begin errors++; $display("FAIL min_mu got %h (timeout %0d) want 8000", mu, to); end
    tick();
  endtask

  task automatic test_rounding();
    logic [N*LW-1:0] v;
    logic [LW-1:0] e_pos, e_neg, e_ramp;
    int n; bit to;
`ifdef NORMALIZE_MEAN_ROUND_EN
    e_pos = 16'h0001; e_neg = 16'h0000; e_ramp = 16'h0000;
`else
    e_pos = 16'h0000; e_neg = 16'hFFFF; e_ramp = 16'hFFFF;
`endif
    v = '0; v[15:0] = 16'h0020;
    send(v); wait_valid(n, to);
    checks++; if (to || mu !== e_pos) begin errors++; $display("FAIL round_pos got %h (timeout %0d) want %h", mu, to, e_pos); end
    tick();
    v = '0; v[15:0] = 16'hFFE0;
    send(v); wait_valid(n, to);
    checks++; if (to || mu !== e_neg) begin errors++; $display("FAIL round_neg got %h (timeout %0d) want %h", mu, to, e_neg); end
    tick();
    for (int i = 0; i < N; i++) v[i*LW +: LW] = 16'(i - 32);
    send(v); wait_valid(n, to);
    checks++; if (to || mu !== e_ramp) begin errors++; $display("FAIL ramp_mu got %h (timeout %0d) want %h", mu, to, e_ramp); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [N*LW-1:0] v, v2;
    logic [LW-1:0] e;
    int n; bit to;
`ifdef NORMALIZE_MEAN_ROUND_EN
    e = 16'h005F;
`else
    e = 16'h005E;
`endif
    for (int i = 0; i < N; i++) v[i*LW +: LW] = 16'(3 * i);
    for (int i = 0; i < N; i++) v2[i*LW +: LW] = 16'h0100;
    out_ready = 1'b0;
    send(v);
    wait_valid(n, to);
    checks++; if (to) begin errors++; $display("FAIL bp_timeout got timeout want out_valid"); end
    x_in = v2; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || mu !== e || x_out !== v || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got valid %b mu %h ready %b want valid 1 mu %h ready 0", k, out_valid, mu, in_ready, e);
      end
    end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got valid %b ready %b want 0 1", out_valid, in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_next_accept got ready %b want 0", in_ready); end
    wait_valid(n, to);
    checks++; if (to || mu !== 16'h0100 || x_out !== v2) begin errors++; $display("FAIL bp_next_mu got %h (timeout %0d) want 0100", mu, to); end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [N*LW-1:0] v;
    int n; bit to;
    for (int i = 0; i < N; i++) v[i*LW +: LW] = 16'h1234;
    send(v);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || mu !== 16'h0000) begin
      errors++; $display("FAIL mid_reset got ready %b valid %b mu %h want 1 0 0000", in_ready, out_valid, mu);
    end
    for (int i = 0; i < N; i++) v[i*LW +: LW] = 16'h0004;
    send(v);
    wait_valid(n, to);
    checks++; if (to || n != 9 || mu !== 16'h0004 || x_out !== v) begin
      errors++; $display("FAIL mid_after got mu %h lat %0d (timeout %0d) want 0004 9", mu, n, to);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_rounding();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
